// File: rtl/residual_decompress.sv
// Rebuilds one NUM_PIX-pixel block from a header (base, residual width) and a stream of
// LSB-first packed two's-complement residual words, one pixel per cycle.
module residual_decompress #(
  parameter int PIX_W   = 8,
  parameter int NUM_PIX = 16,
  parameter int WORD_W  = 32,
  parameter int MAX_RW  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hdr_valid,
  output logic                       hdr_ready,
  input  logic [PIX_W-1:0]           hdr_base,
  input  logic [3:0]                 hdr_rw,
  input  logic                       word_valid,
  output logic                       word_ready,
  input  logic [WORD_W-1:0]          word_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_PIX*PIX_W-1:0]   out_pixels,
  output logic                       err
);

  localparam int BUF_W     = 2 * WORD_W;
  localparam int CNT_W     = $clog2(BUF_W + 1);
  localparam int MAX_WORDS = (NUM_PIX * MAX_RW + WORD_W - 1) / WORD_W;
  localparam int WL_W      = $clog2(MAX_WORDS + 1);
  localparam int IDX_W     = $clog2(NUM_PIX);

  typedef enum logic [1:0] {IDLE, UNPACK, DONE} state_t;

  state_t             state_reg, state_next;
  logic [PIX_W-1:0]   base_reg;
  logic [3:0]         rw_reg;
  logic [WL_W-1:0]    words_left_reg;
  logic [IDX_W-1:0]   pix_idx_reg;
  logic [BUF_W-1:0]   buf_reg, buf_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               err_reg;

  logic               hdr_ok, hdr_fire, word_fire, extract, last_pix;
  logic [WL_W-1:0]    words_init;
  logic [CNT_W-1:0]   shift_amt, cnt_after;
  logic [BUF_W-1:0]   buf_shift, word_ext;
  logic [PIX_W-1:0]   res, pix_val;
  logic               sign_bit;

  assign hdr_ok     = hdr_rw <= 4'(MAX_RW);
  assign words_init = WL_W'((NUM_PIX * int'(hdr_rw) + WORD_W - 1) / WORD_W);
  assign hdr_fire   = hdr_valid && hdr_ready;
  assign word_fire  = word_valid && word_ready;
  assign last_pix   = pix_idx_reg == IDX_W'(NUM_PIX - 1);
  assign err        = err_reg;

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    hdr_ready  = 1'b0;
    word_ready = 1'b0;
    out_valid  = 1'b0;
    extract    = 1'b0;
    case (state_reg)
      IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid && hdr_ok) state_next = UNPACK;
      end
      UNPACK: begin
        word_ready = (words_left_reg != '0) && (count_reg <= CNT_W'(WORD_W));
        extract    = count_reg >= CNT_W'(rw_reg);
        if (extract && last_pix) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Consume rw bits from the bottom, then append an accepted word just above what remains.
  always_comb begin
    shift_amt  = extract ? CNT_W'(rw_reg) : '0;
    buf_shift  = buf_reg >> shift_amt;
    cnt_after  = count_reg - shift_amt;
    word_ext   = BUF_W'(word_data);
    buf_next   = word_fire ? (buf_shift | (word_ext << cnt_after)) : buf_shift;
    count_next = cnt_after + (word_fire ? CNT_W'(WORD_W) : '0);
  end

  always_comb begin
    sign_bit = 1'b0;
    res      = '0;
    for (int k = 0; k < PIX_W; k++) begin
      if (k == int'(rw_reg) - 1) sign_bit = buf_reg[k];
    end
    for (int k = 0; k < PIX_W; k++) begin
      res[k] = (k < int'(rw_reg)) ? buf_reg[k] : sign_bit;
    end
    pix_val = base_reg + res;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      base_reg       <= '0;
      rw_reg         <= '0;
      words_left_reg <= '0;
      pix_idx_reg    <= '0;
      buf_reg        <= '0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      err_reg <= hdr_fire && !hdr_ok;
      if (state_reg == IDLE && hdr_valid && hdr_ok) begin
        base_reg       <= hdr_base;
        rw_reg         <= hdr_rw;
        words_left_reg <= words_init;
        pix_idx_reg    <= '0;
        buf_reg        <= '0;
        count_reg      <= '0;
      end else if (state_reg == UNPACK) begin
        // Padding left in the final word is dropped once the last pixel is out.
        if (extract && last_pix) begin
          buf_reg   <= '0;
          count_reg <= '0;
        end else begin
          buf_reg   <= buf_next;
          count_reg <= count_next;
        end
        if (word_fire) words_left_reg <= words_left_reg - WL_W'(1);
        if (extract)   pix_idx_reg    <= pix_idx_reg + IDX_W'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PIX; gi++) begin : g_pix
      logic [PIX_W-1:0] pix_reg;
      always_ff @(posedge clk) begin
        if (!rst)                                          pix_reg <= '0;
        else if (extract && pix_idx_reg == IDX_W'(gi))     pix_reg <= pix_val;
      end
      assign out_pixels[gi*PIX_W +: PIX_W] = pix_reg;
    end
  endgenerate

endmodule

// File: tb/tb_residual_decompress.sv
// Scoreboard bench for residual_decompress: expected blocks queued at stimulus time,
// compared when the block appears on out_pixels.
module tb_residual_decompress;
  localparam int PIX_W   = 8;
  localparam int NUM_PIX = 16;
  localparam int WORD_W  = 32;
  localparam int MAX_RW  = 8;
  localparam int BLK_W   = NUM_PIX * PIX_W;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               hdr_valid = 1'b0;
  logic               hdr_ready;
  logic [PIX_W-1:0]   hdr_base = '0;
  logic [3:0]         hdr_rw = '0;
  logic               word_valid = 1'b0;
  logic               word_ready;
  logic [WORD_W-1:0]  word_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [BLK_W-1:0]   out_pixels;
  logic               err;

  residual_decompress #(.PIX_W(PIX_W), .NUM_PIX(NUM_PIX), .WORD_W(WORD_W), .MAX_RW(MAX_RW)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_base(hdr_base), .hdr_rw(hdr_rw),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixels(out_pixels), .err(err)
  );

  always #5 clk = ~clk;

  logic [WORD_W-1:0] word_q[$];
  logic [BLK_W-1:0]  exp_q[$];
  int words_taken = 0;
  bit gap_en = 1'b0;
  int tests = 0;
  int fails = 0;

  // Word source: offers the head of word_q, pops it on a handshake.
  initial begin
    forever begin
      bit fire;
      @(negedge clk);
      fire = word_valid && word_ready && rst;
      @(posedge clk);
      if (fire && word_q.size() > 0) begin
        void'(word_q.pop_front());
        words_taken++;
      end
      #2;
      if (word_q.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
        word_valid = 1'b1;
        word_data  = word_q[0];
      end else begin
        word_valid = 1'b0;
        word_data  = '0;
      end
    end
  end

  task automatic send_header(input logic [PIX_W-1:0] b, input logic [3:0] rw, output bit ok);
    bit fire;
    hdr_base  = b;
    hdr_rw    = rw;
    hdr_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      fire = hdr_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        ok = 1'b1;
        break;
      end
    end
    hdr_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_block(input logic [PIX_W-1:0] b, input logic [3:0] rw,
                          output logic [BLK_W-1:0] got, output int cyc, output bit ok);
    bit hok;
    got = '0;
    cyc = 0;
    send_header(b, rw, hok);
    if (!hok) begin
      ok = 1'b0;
      return;
    end
    wait_out(cyc, ok);
    got = out_pixels;
    $display("[TB] block base=%02h rw=%0d out_valid_cycle=%0d pixels=%h", b, rw, cyc, got);
    if (ok && out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic build_random(input logic [PIX_W-1:0] b, input logic [3:0] rw);
    logic [NUM_PIX*MAX_RW+WORD_W-1:0] stream;
    logic [BLK_W-1:0] e;
    int r, sv, nw;
    stream = '0;
    e = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      r  = (rw == 0) ? 0 : int'($urandom_range(0, (1 << rw) - 1));
      sv = (rw > 0 && r >= (1 << (rw - 1))) ? r - (1 << rw) : r;
      e[i*PIX_W +: PIX_W] = 8'(int'(b) + sv);
      for (int k = 0; k < int'(rw); k++) stream[i*int'(rw) + k] = r[k];
    end
    nw = (NUM_PIX * int'(rw) + WORD_W - 1) / WORD_W;
    for (int j = 0; j < nw; j++) word_q.push_back(stream[j*WORD_W +: WORD_W]);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if (out_pixels !== '0) begin fails++; $display("FAIL reset_out_pixels got=%h exp=0", out_pixels); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (word_ready !== 1'b0) begin fails++; $display("FAIL reset_word_ready got=%b exp=0", word_ready); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (hdr_ready !== 1'b1) begin fails++; $display("FAIL reset_hdr_ready got=%b exp=1", hdr_ready); end
  endtask

  task automatic test_rw0();
    logic [BLK_W-1:0] got, e;
    int cyc, start;
    bit ok;
    word_q.push_back(32'hDEAD_BEEF);
    e = {NUM_PIX{8'h80}};
    exp_q.push_back(e);
    start = words_taken;
    @(posedge clk);
    #1;
    do_block(8'h80, 4'd0, got, cyc, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rw0_timeout got=none exp=out_valid"); end
    tests++; if (cyc !== 17) begin fails++; $display("FAIL rw0_latency got=%0d exp=17", cyc); end
    e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL rw0_pixels got=%h exp=%h", got, e); end
    tests++; if (words_taken !== start) begin fails++; $display("FAIL rw0_words got=%0d exp=%0d", words_taken - start, 0); end
    word_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_rw4();
    logic [BLK_W-1:0] got, e;
    int cyc, start;
    bit ok;
    word_q.push_back(32'h7654_3210);
    word_q.push_back(32'hFEDC_BA98);
    for (int i = 0; i < NUM_PIX; i++) e[i*PIX_W +: PIX_W] = (i < 8) ? 8'(100 + i) : 8'(92 + i - 8);
    exp_q.push_back(e);
    start = words_taken;
    @(posedge clk);
    #1;
    do_block(8'd100, 4'd4, got, cyc, ok);
    tests++; if (!ok) begin fails++; $display("FAIL rw4_timeout got=none exp=out_valid"); end
    tests++; if (cyc !== 18) begin fails++; $display("FAIL rw4_latency got=%0d exp=18", cyc); end
    e = exp_q.pop_front();
    tests++; if (got !== e) begin fails++; $display("FAIL rw4_pixels got=%h exp=%h", got, e); end
    tests++; if (words_taken - start !== 2) begin fails++; $display("FAIL rw4_words got=%0d exp=2", words_taken - start); end
  endtask

  task automatic test_wrap();
    logic [BLK_W-1:0] got, e;
    int cyc;
    bit ok;
    word_q.push_back(32'h0000_0001);
    e = {NUM_PIX{8'hFF}};
    e[7:0] = 8'h00;
    exp_q.push_back(e);
    do_block(8'hFF, 4'd2, got, cyc, ok);
    e = exp_q.pop_front();
    tests++; if (!ok || got !== e) begin fails++; $display("FAIL wrap_up got=%h exp=%h", got, e); end
    word_q.push_back(32'h0000_0003);
    e = '0;
    e[7:0] = 8'hFF;
    exp_q.push_back(e);
    do_block(8'h00, 4'd2, got, cyc, ok);
    e = exp_q.pop_front();
    tests++; if (!ok || got !== e) begin fails++; $display("FAIL wrap_down got=%h exp=%h", got, e); end
  endtask

  task automatic test_backpressure();
    logic [BLK_W-1:0] got, held, e;
    logic [PIX_W-1:0] b2;
    int cyc;
    bit ok;
    out_ready = 1'b0;
    build_random(8'h3C, 4'd3);
    do_block(8'h3C, 4'd3, got, cyc, ok);
    e = exp_q.pop_front();
    tests++; if (!ok || got !== e) begin fails++; $display("FAIL bp_first_pixels got=%h exp=%h", got, e); end
    held = got;
    b2 = 8'($urandom);
    build_random(b2, 4'd6);
    hdr_base  = b2;
    hdr_rw    = 4'd6;
    hdr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests++; if (out_valid !== 1'b1 || out_pixels !== held) begin fails++; $display("FAIL bp_hold c=%0d valid=%b got=%h exp=%h", c, out_valid, out_pixels, held); end
      tests++; if (hdr_ready !== 1'b0) begin fails++; $display("FAIL bp_hdr_ready c=%0d got=%b exp=0", c, hdr_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release got=%b exp=0", out_valid); end
    do_block(b2, 4'd6, got, cyc, ok);
    e = exp_q.pop_front();
    tests++; if (!ok || got !== e) begin fails++; $display("FAIL bp_second_pixels got=%h exp=%h", got, e); end
  endtask

  task automatic test_err();
    int start;
    bit ok;
    word_q.push_back(32'h1234_5678);
    start = words_taken;
    @(posedge clk);
    #1;
    send_header(8'h11, 4'd9, ok);
    tests++; if (!ok || err !== 1'b1) begin fails++; $display("FAIL err_pulse got=%b exp=1", err); end
    tests++; if (word_ready !== 1'b0 || hdr_ready !== 1'b1) begin fails++; $display("FAIL err_idle word_ready=%b hdr_ready=%b exp=0/1", word_ready, hdr_ready); end
    @(posedge clk);
    #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clear got=%b exp=0", err); end
    repeat (3) @(posedge clk);
    #1;
    tests++; if (words_taken !== start || out_valid !== 1'b0) begin fails++; $display("FAIL err_no_words got=%0d exp=0", words_taken - start); end
    word_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [BLK_W-1:0] got, e;
    int cyc;
    bit ok;
    build_random(8'h5A, 4'd5);
    send_header(8'h5A, 4'd5, ok);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tests++; if (out_valid !== 1'b0 || hdr_ready !== 1'b1 || word_ready !== 1'b0) begin fails++; $display("FAIL rstmid_state out_valid=%b hdr_ready=%b word_ready=%b exp=0/1/0", out_valid, hdr_ready, word_ready); end
    word_q.delete();
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    build_random(8'hA7, 4'd7);
    do_block(8'hA7, 4'd7, got, cyc, ok);
    e = exp_q.pop_front();
    tests++; if (!ok || got !== e) begin fails++; $display("FAIL rstmid_next got=%h exp=%h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic [BLK_W-1:0] got, e;
    logic [PIX_W-1:0] b;
    logic [3:0] rw;
    int cyc;
    bit ok;
    gap_en = 1'b1;
    for (int n = 0; n < 10; n++) begin
      rw = (n == 0) ? 4'd0 : (n == 1) ? 4'd8 : (n == 2) ? 4'd1 : 4'($urandom_range(0, MAX_RW));
      b  = 8'($urandom);
      build_random(b, rw);
      do_block(b, rw, got, cyc, ok);
      e = exp_q.pop_front();
      tests++; if (!ok || got !== e) begin fails++; $display("FAIL b2b_%0d rw=%0d got=%h exp=%h", n, rw, got, e); end
    end
    gap_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rw0();
    test_rw4();
    test_wrap();
    test_backpressure();
    test_err();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
